// File: rtl/led_color_mixer_if.sv
// ---------------------------------------------------------------------------
// led_color_mixer_if
// Bundles the pattern/button/control inputs and the LED/selection outputs of
// led_color_mixer.
//   i_led    : pattern word to display (N_LEDS)
//   i_btn    : raw colour buttons, asynchronous level (N_COLORS)
//   i_mode   : 0 = exclusive selection, 1 = mix (toggle per colour)
//   i_clear  : deselect all colours (synchronous level)
//   i_duty   : PWM brightness, on-time = i_duty / 2^PWM_BITS
//   o_sel    : selected-colour mask
//   o_active : any colour selected
//   o_led    : LED banks, bank c at [c*N_LEDS +: N_LEDS]
// master = the driver of the pattern/buttons, slave = the mixer.
// ---------------------------------------------------------------------------
interface led_color_mixer_if #(
  parameter int N_LEDS   = 4,
  parameter int N_COLORS = 3,
  parameter int PWM_BITS = 4
);
  logic [N_LEDS-1:0]          i_led;
  logic [N_COLORS-1:0]        i_btn;
  logic                       i_mode;
  logic                       i_clear;
  logic [PWM_BITS-1:0]        i_duty;
  logic [N_COLORS-1:0]        o_sel;
  logic                       o_active;
  logic [N_COLORS*N_LEDS-1:0] o_led;

  modport master (
    output i_led, i_btn, i_mode, i_clear, i_duty,
    input  o_sel, o_active, o_led
  );

  modport slave (
    input  i_led, i_btn, i_mode, i_clear, i_duty,
    output o_sel, o_active, o_led
  );
endinterface

// File: rtl/led_color_mixer.sv
// ---------------------------------------------------------------------------
// led_color_mixer
// Routes a pattern word onto one (exclusive mode) or several (mix mode) of
// N_COLORS LED colour banks, selected by synchronised, edge-detected colour
// buttons, and dims every active bank with a global PWM duty.
// Ports:
//   clk     : system clock
//   i_reset : asynchronous, active-high reset
//   bus     : led_color_mixer_if.slave (pattern, buttons, mode, clear,
//             duty in; selection mask, active flag, LED banks out)
// ---------------------------------------------------------------------------
module led_color_mixer #(
  parameter int N_LEDS   = 4,
  parameter int N_COLORS = 3,
  parameter int PWM_BITS = 4
) (
  input  logic              clk,
  input  logic              i_reset,
  led_color_mixer_if.slave  bus
);

  // One-hot of the lowest set bit of x (zero when x is zero).
  function automatic logic [N_COLORS-1:0] f_lowest_bit(input logic [N_COLORS-1:0] x);
    logic [N_COLORS-1:0] r;
    logic                found;
    r     = {N_COLORS{1'b0}};
    found = 1'b0;
    for (int i = 0; i < N_COLORS; i++) begin
      if (x[i] && !found) begin
        r[i]  = 1'b1;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return r;
  endfunction

  logic [N_COLORS-1:0]        r_s1;
  logic [N_COLORS-1:0]        r_s2;
  logic [N_COLORS-1:0]        r_p;
  logic [N_COLORS-1:0]        r_sel;
  logic                       r_active;
  logic [PWM_BITS-1:0]        r_cnt;
  logic [N_COLORS*N_LEDS-1:0] r_led;

  logic [N_COLORS-1:0]        w_press;
  logic [N_COLORS-1:0]        w_sel_next;
  logic                       w_pwm_on;
  logic [N_COLORS*N_LEDS-1:0] w_led_next;

  // Rising edge of the synchronised button: one cycle wide, held buttons
  // produce a single event, releases are ignored.
  assign w_press  = r_s2 & ~r_p;
  assign w_pwm_on = (r_cnt < bus.i_duty);

  // Button synchroniser and previous-value history.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_s1 <= {N_COLORS{1'b0}};
      r_s2 <= {N_COLORS{1'b0}};
      r_p  <= {N_COLORS{1'b0}};
    end else begin
      r_s1 <= bus.i_btn;
      r_s2 <= r_s1;
      r_p  <= r_s2;
    end
  end

  // Next selection: clear wins over presses; exclusive mode keeps at most one
  // bit (a multi-hot mask left over from mix mode collapses to its lowest
  // bit); mix mode toggles every pressed colour.
  always_comb begin
    w_sel_next = r_sel;
    if (bus.i_clear) begin
      w_sel_next = {N_COLORS{1'b0}};
    end else if (!bus.i_mode) begin
      if (|w_press) begin
        w_sel_next = f_lowest_bit(w_press);
      end else if (f_lowest_bit(r_sel) != r_sel) begin
        w_sel_next = f_lowest_bit(r_sel);
      end else begin
        w_sel_next = r_sel;
      end
    end else begin
      w_sel_next = r_sel ^ w_press;
    end
  end

  // Selection register and its registered any-selected flag.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_sel    <= {N_COLORS{1'b0}};
      r_active <= 1'b0;
    end else begin
      r_sel    <= w_sel_next;
      r_active <= |w_sel_next;
    end
  end

  // Free-running PWM phase counter, wraps naturally at 2^PWM_BITS.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= {PWM_BITS{1'b0}};
    end else begin
      r_cnt <= r_cnt + PWM_BITS'(1);
    end
  end

  // Gate the pattern per bank with its selection bit and the PWM phase.
  always_comb begin
    w_led_next = {(N_COLORS*N_LEDS){1'b0}};
    for (int c = 0; c < N_COLORS; c++) begin
      w_led_next[c*N_LEDS +: N_LEDS] = bus.i_led & {N_LEDS{r_sel[c] & w_pwm_on}};
    end
  end

  // Registered LED bank outputs.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_led <= {(N_COLORS*N_LEDS){1'b0}};
    end else begin
      r_led <= w_led_next;
    end
  end

  assign bus.o_sel    = r_sel;
  assign bus.o_active = r_active;
  assign bus.o_led    = r_led;

endmodule

// File: tb/tb_led_color_mixer.sv
// ---------------------------------------------------------------------------
// tb_led_color_mixer
// Directed scenarios plus a randomized run, each compared against a
// behavioural model: button press = "sampled high two edges ago and low three
// edges ago", selection rules applied literally, PWM phase = edges since
// reset release modulo 2^PWM_BITS.
// ---------------------------------------------------------------------------
module tb_led_color_mixer;
  localparam int NL = 4;
  localparam int NC = 3;
  localparam int PB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  led_color_mixer_if #(.N_LEDS(NL), .N_COLORS(NC), .PWM_BITS(PB)) bus ();

  led_color_mixer #(.N_LEDS(NL), .N_COLORS(NC), .PWM_BITS(PB)) dut (
    .clk     (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model state
  logic [NC-1:0]    m_sel;
  logic [NC*NL-1:0] m_led;
  int               m_n;
  logic [NC-1:0]    m_hist[$];

  task automatic model_clear();
    m_sel = '0;
    m_led = '0;
    m_n   = 0;
    m_hist.delete();
  endtask

  // Advance one clock edge and update the model with the inputs sampled there;
  // returns 1 time unit after the edge.
  task automatic tick();
    logic [NC-1:0] press, prev1, prev2;
    int            phase, low;
    bit            pwm;
    @(posedge clk);
    phase = m_n % (1 << PB);
    pwm   = (phase < int'(bus.i_duty));
    for (int c = 0; c < NC; c++)
      m_led[c*NL +: NL] = (m_sel[c] && pwm) ? bus.i_led : '0;
    prev1 = (m_hist.size() > 1) ? m_hist[1] : '0;
    prev2 = (m_hist.size() > 2) ? m_hist[2] : '0;
    press = prev1 & ~prev2;
    m_hist.push_front(bus.i_btn);
    if (m_hist.size() > 3) void'(m_hist.pop_back());
    if (bus.i_clear) begin
      m_sel = '0;
    end else if (!bus.i_mode) begin
      if (press != 0) begin
        low = 0;
        for (int c = NC - 1; c >= 0; c--) if (press[c]) low = c;
        m_sel = NC'(1) << low;
      end else if ($countones(m_sel) > 1) begin
        low = 0;
        for (int c = NC - 1; c >= 0; c--) if (m_sel[c]) low = c;
        m_sel = NC'(1) << low;
      end
    end else begin
      m_sel = m_sel ^ press;
    end
    m_n++;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    bus.i_btn = '0; bus.i_duty = 4'hF; bus.i_mode = 1'b0; bus.i_clear = 1'b0;
    bus.i_led = 4'b1111;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.o_sel !== 3'b000 || bus.o_active !== 1'b0 || bus.o_led !== 12'h000) begin
      errors++;
      $display("FAIL reset_async: sel=%b act=%b led=%h expected 000/0/000",
               bus.o_sel, bus.o_active, bus.o_led);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.o_sel !== 3'b000 || bus.o_active !== 1'b0 || bus.o_led !== 12'h000) begin
      errors++;
      $display("FAIL reset_held: sel=%b act=%b led=%h expected 000/0/000",
               bus.o_sel, bus.o_active, bus.o_led);
    end
    release_reset();
    #1;
    checks++;
    if (dut.r_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d expected 0", dut.r_cnt);
    end
    repeat (3) begin
      tick();
      checks++;
      if (bus.o_sel !== m_sel || bus.o_active !== (m_sel != 0) || bus.o_led !== m_led) begin
        errors++;
        $display("FAIL reset_idle: sel=%b led=%h expected sel=%b led=%h",
                 bus.o_sel, bus.o_led, m_sel, m_led);
      end
    end
  endtask

  task automatic test_exclusive();
    logic [2:0] exp_sel [0:2];
    int on_cnt;
    exp_sel = '{3'b000, 3'b000, 3'b010};
    bus.i_mode = 1'b0; bus.i_duty = 4'h0; bus.i_led = 4'b1010; bus.i_btn = 3'b000;
    repeat (2) tick();
    bus.i_btn = 3'b010;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i < 3) begin
        checks++;
        if (bus.o_sel !== exp_sel[i]) begin
          errors++;
          $display("FAIL excl_latency[%0d]: got %b expected %b", i, bus.o_sel, exp_sel[i]);
        end
      end
      checks++;
      if (bus.o_led !== 12'h000 || bus.o_led !== m_led) begin
        errors++;
        $display("FAIL excl_duty0: got %h expected 000", bus.o_led);
      end
    end
    bus.i_btn = 3'b000;
    bus.i_duty = 4'hF;
    tick();
    on_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (bus.o_led[7:4] == 4'b1010) on_cnt++;
      checks++;
      if (bus.o_led !== m_led || bus.o_sel !== 3'b010) begin
        errors++;
        $display("FAIL excl_pwm: led=%h sel=%b expected led=%h sel=010",
                 bus.o_led, bus.o_sel, m_led);
      end
    end
    checks++;
    if (on_cnt !== 30) begin
      errors++;
      $display("FAIL excl_on_count: got %0d expected 30", on_cnt);
    end
  endtask

  task automatic test_simultaneous();
    bus.i_clear = 1'b1; tick(); bus.i_clear = 1'b0;
    bus.i_mode = 1'b0; bus.i_btn = 3'b110;
    repeat (3) tick();
    checks++;
    if (bus.o_sel !== 3'b010 || m_sel !== 3'b010) begin
      errors++;
      $display("FAIL simul_excl: got %b expected 010", bus.o_sel);
    end
    bus.i_btn = 3'b000; repeat (3) tick();
    bus.i_mode = 1'b1; bus.i_btn = 3'b101;
    repeat (3) tick();
    checks++;
    if (bus.o_sel !== 3'b111 || bus.o_sel !== m_sel) begin
      errors++;
      $display("FAIL simul_mix: got %b expected 111", bus.o_sel);
    end
    bus.i_btn = 3'b000; repeat (3) tick();
  endtask

  task automatic test_mix();
    logic [2:0] pr  [0:5];
    logic [2:0] exp [0:5];
    pr  = '{3'b001, 3'b100, 3'b001, 3'b100, 3'b010, 3'b100};
    exp = '{3'b001, 3'b101, 3'b100, 3'b000, 3'b010, 3'b110};
    bus.i_clear = 1'b1; tick(); bus.i_clear = 1'b0;
    bus.i_mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.i_btn = pr[i]; tick();
      bus.i_btn = 3'b000; repeat (3) tick();
      checks++;
      if (bus.o_sel !== exp[i] || bus.o_active !== (exp[i] != 3'b000) || m_sel !== exp[i]) begin
        errors++;
        $display("FAIL mix_step[%0d]: sel=%b act=%b expected %b", i, bus.o_sel, bus.o_active, exp[i]);
      end
    end
    bus.i_mode = 1'b0;
    tick();
    checks++;
    if (bus.o_sel !== 3'b010) begin
      errors++;
      $display("FAIL mix_to_excl: got %b expected 010", bus.o_sel);
    end
  endtask

  task automatic test_clear_priority();
    bus.i_mode = 1'b0;
    bus.i_clear = 1'b1; tick(); bus.i_clear = 1'b0;
    bus.i_btn = 3'b001; tick(); bus.i_btn = 3'b000; repeat (3) tick();
    checks++;
    if (bus.o_sel !== 3'b001) begin
      errors++;
      $display("FAIL clr_setup: got %b expected 001", bus.o_sel);
    end
    bus.i_btn = 3'b100;
    repeat (2) tick();
    bus.i_clear = 1'b1;
    tick();
    checks++;
    if (bus.o_sel !== 3'b000) begin
      errors++;
      $display("FAIL clr_coincide: got %b expected 000", bus.o_sel);
    end
    bus.i_clear = 1'b0;
    repeat (4) begin
      tick();
      checks++;
      if (bus.o_sel !== 3'b000 || bus.o_led !== m_led || bus.o_active !== 1'b0) begin
        errors++;
        $display("FAIL clr_held: sel=%b led=%h expected 000 led=%h", bus.o_sel, bus.o_led, m_led);
      end
    end
    bus.i_btn = 3'b000; tick();
  endtask

  task automatic test_pwm();
    int on_cnt;
    bus.i_duty = 4'd4; bus.i_led = 4'b1111; bus.i_mode = 1'b0;
    bus.i_btn = 3'b001; tick(); bus.i_btn = 3'b000; repeat (3) tick();
    on_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (bus.o_led[3:0] == 4'b1111) on_cnt++;
      checks++;
      if (bus.o_led !== m_led) begin
        errors++;
        $display("FAIL pwm_phase: got %h expected %h", bus.o_led, m_led);
      end
    end
    checks++;
    if (on_cnt !== 8) begin
      errors++;
      $display("FAIL pwm_on_count: got %0d expected 8", on_cnt);
    end
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.o_sel !== 3'b000 || bus.o_active !== 1'b0 || bus.o_led !== 12'h000) begin
      errors++;
      $display("FAIL pwm_midreset: sel=%b act=%b led=%h expected 000/0/000",
               bus.o_sel, bus.o_active, bus.o_led);
    end
    release_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      bus.i_led = NL'($urandom);
      for (int c = 0; c < NC; c++)
        if ($urandom_range(0, 7) == 0) bus.i_btn[c] = ~bus.i_btn[c];
      if ($urandom_range(0, 19) == 0) bus.i_mode = ~bus.i_mode;
      bus.i_clear = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 15) == 0) bus.i_duty = PB'($urandom);
      if (i == 700) begin
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.o_sel !== 3'b000 || bus.o_led !== 12'h000 || bus.o_active !== 1'b0) begin
          errors++;
          $display("FAIL rand_reset: sel=%b led=%h expected 000/000", bus.o_sel, bus.o_led);
        end
        bus.i_btn = 3'b011;
        release_reset();
      end
      tick();
      checks++;
      if (bus.o_sel !== m_sel || bus.o_active !== (m_sel != 0) || bus.o_led !== m_led) begin
        errors++;
        $display("FAIL rand[%0d]: sel=%b act=%b led=%h expected sel=%b led=%h",
                 i, bus.o_sel, bus.o_active, bus.o_led, m_sel, m_led);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.i_btn = '0; bus.i_led = '0; bus.i_mode = 1'b0; bus.i_clear = 1'b0; bus.i_duty = '0;
    model_clear();
    test_reset();
    test_exclusive();
    test_simultaneous();
    test_mix();
    test_clear_priority();
    test_pwm();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_color_mixer.md
# led_color_mixer

Parametrised RGB-channel LED selector: routes a pattern word (from the flash or shift generator) onto one of N_COLORS LED colour banks, or onto several at once in mix mode. Buttons are synchronised and edge-detected internally, and a global PWM duty dims all active banks. Sits between the pattern generators and the board LED pins, replacing the fixed 3-colour, 4-state selector.

## Interface
- N_LEDS, 4, LEDs per colour bank (≥1)
- N_COLORS, 3, number of colour channels/buttons (≥1)
- PWM_BITS, 4, width of PWM counter and duty input (≥1)

- clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_led  in  N_LEDS  pattern word to display
- i_btn  in  N_COLORS  raw colour buttons, asynchronous, level
- i_mode  in  1  0 = exclusive (one colour), 1 = mix (toggle per colour); synchronous
- i_clear  in  1  synchronous level; deselect all colours
- i_duty  in  PWM_BITS  brightness; 0 = off, on-time = i_duty / 2^PWM_BITS
- o_sel  out  N_COLORS  selected-colour mask (colour indicator LEDs)
- o_active  out  1  |o_sel
- o_led  out  N_COLORS*N_LEDS  bank c at bits [c*N_LEDS +: N_LEDS]

## Operation
- Per button: 2-flop synchroniser (s1, s2) plus a previous-value flop (p). Press event press[c] = s2[c] & ~p[c]. Falling edges are ignored.
- Selection register sel (N_COLORS), drives o_sel directly. Update priority, evaluated each cycle:
  1. i_clear = 1 → sel = 0; press events that cycle are discarded.
  2. i_mode = 0 (exclusive), any press: sel = one-hot of the lowest-index pressed c. Pressing the already-selected colour keeps it. No press and sel multi-hot → sel reduced to its lowest set bit. Otherwise hold.
  3. i_mode = 1 (mix): sel = sel ^ press; every simultaneous press toggles its own bit.
- Effective states: IDLE (sel = 0) and ACTIVE (sel ≠ 0). Leaving ACTIVE is possible only via i_clear or by toggling off the last bit in mix mode.
- PWM: free-running PWM_BITS counter cnt, wraps 2^PWM_BITS−1 → 0. pwm_on = (cnt < i_duty), unsigned compare. i_duty = 0 → never on. Maximum i_duty → on for (2^PWM_BITS−1) of every 2^PWM_BITS cycles.
- o_led bank c (registered) = i_led & {N_LEDS{sel[c] & pwm_on}}; unselected banks are 0.
- i_duty and i_mode may change at any cycle and take effect on the next edge. No glitch handling beyond that.

## Timing
- Reset, asynchronous: s1, s2, p, sel, cnt, o_led all 0. Hence o_sel = 0, o_active = 0, o_led = 0 while i_reset is high and until the first update after release.
- A button held high through reset release is treated as a new press. Its s2 rises 2 edges after release with p = 0.
- Button latency: i_btn[c] high and sampled at edge k → press valid between edges k+1 and k+2 → o_sel updates at edge k+2 → o_led reflects it at edge k+3.
- A press is exactly one cycle wide. A held button produces a single event.
- i_clear high at edge k → o_sel = 0 after edge k, o_led = 0 after edge k+1.
- o_led lags i_led, sel and pwm_on by 1 cycle.
- Reset mid-operation clears everything immediately, asynchronously. cnt restarts from 0.

## Test plan
- Reset/idle: assert i_reset with i_btn=3'b000 and i_duty=4'hF → o_sel, o_active and o_led stay 0; cnt = 0 after release.
- Exclusive select: i_mode=0, i_duty=0, i_led=4'b1010. Pulse i_btn[1] high for 5 cycles at edge k → o_sel=3'b010 from edge k+2. o_led stays 0 (duty 0). Set i_duty=4'hF → bank 1 = 4'b1010 for 15 of 16 cycles, 0 in the cycle after cnt=15.
- Simultaneous press: i_mode=0, i_btn 0→3'b110 in one cycle → o_sel=3'b010. Then i_mode=1 and press 3'b101 simultaneously → o_sel=3'b111.
- Mix toggle/mode change: i_mode=1, press colour 0 then colour 2 → o_sel=3'b101. Press colour 0 again → 3'b100, then press colour 2 → 3'b000, o_active=0. Rebuild to 3'b110, set i_mode=0 → o_sel=3'b010 on the next edge.
- Clear priority: o_sel=3'b001, i_clear and i_btn[2] rise so press and clear coincide → o_sel=0 and the press is dropped. Held button generates no further event after i_clear falls.
- PWM duty: i_duty=4'd4 with one colour selected → o_led bank high for exactly 4 consecutive cycles per 16, aligned 1 cycle after cnt=0..3. Assert i_reset mid-period → outputs 0 immediately.
